// File: rtl/fifo_level.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_level
// Purpose  : Synchronous valid/ready FIFO of any depth >= 1, with occupancy
//            count, registered almost-full / almost-empty flags, synchronous
//            flush and optional combinational fall-through when empty.
// Ports    : clk          - rising-edge clock
//            rstn         - asynchronous active-low reset
//            flush        - synchronous discard of all contents
//            w_valid/w_ready/w_data - write side handshake and payload
//            r_valid/r_ready/r_data - read side handshake and head payload
//            level        - number of stored entries, 0..DEPTH
//            almost_full  - level >= ALMOST_FULL
//            almost_empty - level <= ALMOST_EMPTY
// Revision : 1.0 - initial release
// ============================================================================
module fifo_level #(
  parameter int  DATA_WIDTH   = 1,
  parameter type TYPE         = logic [DATA_WIDTH-1:0],
  parameter int  DEPTH        = 4,
  parameter bit  FALL_THROUGH = 1'b0,
  parameter int  ALMOST_FULL  = DEPTH,
  parameter int  ALMOST_EMPTY = 0,
  localparam int LW           = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          w_valid,
  output logic          w_ready,
  input  TYPE           w_data,
  output logic          r_valid,
  input  logic          r_ready,
  output TYPE           r_data,
  output logic [LW-1:0] level,
  output logic          almost_full,
  output logic          almost_empty
);

  // Pointer width; a single-entry FIFO still gets a 1-bit pointer that
  // simply never leaves 0.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AFULL = LW'(ALMOST_FULL);
  localparam logic [LW-1:0] LVL_AEMPT = LW'(ALMOST_EMPTY);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (DEPTH < 1) begin : g_chk_depth
    $fatal(1, "fifo_level: DEPTH must be at least 1");
  end
  if ((ALMOST_FULL < 1) || (ALMOST_FULL > DEPTH)) begin : g_chk_afull
    $fatal(1, "fifo_level: ALMOST_FULL must be in 1..DEPTH");
  end
  if ((ALMOST_EMPTY < 0) || (ALMOST_EMPTY > DEPTH - 1)) begin : g_chk_aempty
    $fatal(1, "fifo_level: ALMOST_EMPTY must be in 0..DEPTH-1");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  TYPE           mem_q [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;

  logic full;
  logic empty;
  logic w_hs;
  logic r_hs;
  logic bypass;
  logic push;
  logic pop;

  // level is the only occupancy record; full/empty derive from it so the
  // pointers never need an extra wrap bit.
  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);

  assign w_ready = !full && !flush;
  assign r_valid = !flush && (!empty || (FALL_THROUGH && w_valid));
  assign r_data  = (FALL_THROUGH && empty) ? w_data : mem_q[rptr_q];

  assign w_hs = w_valid && w_ready;
  assign r_hs = r_valid && r_ready;

  // A read while empty is only possible through the fall-through path, so
  // the word goes straight out and the storage is left untouched.
  assign bypass = FALL_THROUGH && empty && w_hs && r_hs;
  assign push   = w_hs && !bypass;
  assign pop    = r_hs && !bypass;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    level_d = level_q;

    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) begin
        wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end

    // Flags are registered from level_d so they line up with level_q.
    afull_d  = (level_d >= LVL_AFULL);
    aempty_d = (level_d <= LVL_AEMPT);
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rptr_q   <= '0;
      wptr_q   <= '0;
      level_q  <= '0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      level_q  <= level_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  // Storage has no reset; stale words are never exposed because r_data is
  // only meaningful while level is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= w_data;
    end
  end

  assign level        = level_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_level.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fifo_level
// Purpose  : Self-checking bench for fifo_level. Three instances share one
//            input stream: DEPTH=5 registered, DEPTH=5 fall-through, DEPTH=1.
//            A queue-style reference model tracks every instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_level;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flush;
  logic       w_valid;
  logic       r_ready;
  logic [7:0] w_data;

  always #5 clk = ~clk;

  // instance 0 : DEPTH 5, registered
  logic       wr0, rv0, af0, ae0;
  logic [7:0] rd0;
  logic [2:0] lv0;
  // instance 1 : DEPTH 5, fall-through
  logic       wr1, rv1, af1, ae1;
  logic [7:0] rd1;
  logic [2:0] lv1;
  // instance 2 : DEPTH 1
  logic       wr2, rv2, af2, ae2;
  logic [7:0] rd2;
  logic [0:0] lv2;

  fifo_level #(.DATA_WIDTH(8), .DEPTH(5), .FALL_THROUGH(1'b0),
               .ALMOST_FULL(4), .ALMOST_EMPTY(1)) u_d5 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .w_valid(w_valid), .w_ready(wr0), .w_data(w_data),
    .r_valid(rv0), .r_ready(r_ready), .r_data(rd0),
    .level(lv0), .almost_full(af0), .almost_empty(ae0));

  fifo_level #(.DATA_WIDTH(8), .DEPTH(5), .FALL_THROUGH(1'b1),
               .ALMOST_FULL(4), .ALMOST_EMPTY(1)) u_ft (
    .clk(clk), .rstn(rstn), .flush(flush),
    .w_valid(w_valid), .w_ready(wr1), .w_data(w_data),
    .r_valid(rv1), .r_ready(r_ready), .r_data(rd1),
    .level(lv1), .almost_full(af1), .almost_empty(ae1));

  fifo_level #(.DATA_WIDTH(8), .DEPTH(1), .FALL_THROUGH(1'b0)) u_d1 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .w_valid(w_valid), .w_ready(wr2), .w_data(w_data),
    .r_valid(rv2), .r_ready(r_ready), .r_data(rd2),
    .level(lv2), .almost_full(af2), .almost_empty(ae2));

  // Reference model configuration and contents (head of queue at index 0)
  int         MD  [3] = '{5, 5, 1};
  int         MFT [3] = '{0, 1, 0};
  int         MAF [3] = '{4, 4, 1};
  int         MAE [3] = '{1, 1, 0};
  logic [7:0] mm  [3][8];
  int         cnt [3];

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         fl;
    bit         wv;
    logic [7:0] wd;
    bit         rr;
    bit         ewr;
    bit         erv;
    logic [7:0] erd;
    int         elv;
    bit         eaf;
    bit         eae;
  } vec_t;

  vec_t tbl [12];

  task automatic cmp(input string nm, input int inst, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%0d want=%0d t=%0t", nm, inst, act, exp, $time);
    end
  endtask

  task automatic sample(input int i, output bit wr, output bit rv, output bit af,
                        output bit ae, output logic [7:0] rd, output int lv);
    case (i)
      0:       begin wr = wr0; rv = rv0; af = af0; ae = ae0; rd = rd0; lv = int'(lv0); end
      1:       begin wr = wr1; rv = rv1; af = af1; ae = ae1; rd = rd1; lv = int'(lv1); end
      default: begin wr = wr2; rv = rv2; af = af2; ae = ae2; rd = rd2; lv = int'(lv2); end
    endcase
  endtask

  task automatic chk_model(input string tag);
    for (int i = 0; i < 3; i++) begin
      bit wr, rv, af, ae, ewr, erv;
      logic [7:0] rd;
      int lv;
      sample(i, wr, rv, af, ae, rd, lv);
      ewr = !flush && (cnt[i] < MD[i]);
      erv = !flush && ((cnt[i] > 0) || ((MFT[i] == 1) && w_valid));
      cmp({tag, ".w_ready"},      i, int'(wr), int'(ewr));
      cmp({tag, ".r_valid"},      i, int'(rv), int'(erv));
      cmp({tag, ".level"},        i, lv, cnt[i]);
      cmp({tag, ".almost_full"},  i, int'(af), int'(cnt[i] >= MAF[i]));
      cmp({tag, ".almost_empty"}, i, int'(ae), int'(cnt[i] <= MAE[i]));
      if (erv) cmp({tag, ".r_data"}, i, int'(rd), (cnt[i] > 0) ? int'(mm[i][0]) : int'(w_data));
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit wr, rd;
      if (flush) begin
        cnt[i] = 0;
      end else begin
        wr = w_valid && (cnt[i] < MD[i]);
        rd = r_ready && ((cnt[i] > 0) || ((MFT[i] == 1) && w_valid));
        // Reading from an empty queue can only be the fall-through pass.
        if (!((cnt[i] == 0) && wr && rd)) begin
          if (rd) begin
            for (int k = 0; k < 7; k++) mm[i][k] = mm[i][k+1];
            cnt[i]--;
          end
          if (wr) begin
            mm[i][cnt[i]] = w_data;
            cnt[i]++;
          end
        end
      end
    end
  endtask

  task automatic drive(input bit f, input bit wv, input logic [7:0] wd, input bit rr);
    flush = f; w_valid = wv; w_data = wd; r_ready = rr;
  endtask

  // Finish a cycle already positioned at the falling edge.
  task automatic post(input string tag);
    chk_model(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag);
    @(negedge clk);
    post(tag);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) cnt[i] = 0;
  endtask

  initial begin
    // fill DEPTH=5 with 0x10..0x15 (last refused), then drain
    tbl[0]  = '{0, 1, 8'h10, 0, 1, 0, 8'h00, 0, 0, 1};
    tbl[1]  = '{0, 1, 8'h11, 0, 1, 1, 8'h10, 1, 0, 1};
    tbl[2]  = '{0, 1, 8'h12, 0, 1, 1, 8'h10, 2, 0, 0};
    tbl[3]  = '{0, 1, 8'h13, 0, 1, 1, 8'h10, 3, 0, 0};
    tbl[4]  = '{0, 1, 8'h14, 0, 1, 1, 8'h10, 4, 1, 0};
    tbl[5]  = '{0, 1, 8'h15, 0, 0, 1, 8'h10, 5, 1, 0};
    tbl[6]  = '{0, 0, 8'h00, 1, 0, 1, 8'h10, 5, 1, 0};
    tbl[7]  = '{0, 0, 8'h00, 1, 1, 1, 8'h11, 4, 1, 0};
    tbl[8]  = '{0, 0, 8'h00, 1, 1, 1, 8'h12, 3, 0, 0};
    tbl[9]  = '{0, 0, 8'h00, 1, 1, 1, 8'h13, 2, 0, 0};
    tbl[10] = '{0, 0, 8'h00, 1, 1, 1, 8'h14, 1, 0, 1};
    tbl[11] = '{0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1};

    model_clear();
    rstn = 1'b0;
    drive(0, 0, 8'h00, 0);
    #12;
    // reset state
    cmp("rst.level", 0, int'(lv0), 0);
    cmp("rst.w_ready", 0, int'(wr0), 1);
    cmp("rst.r_valid", 0, int'(rv0), 0);
    cmp("rst.almost_empty", 0, int'(ae0), 1);
    cmp("rst.almost_full", 0, int'(af0), 0);
    chk_model("rst");
    w_valid = 1'b1;
    #1;
    cmp("rst.ft_r_valid", 1, int'(rv1), 1);
    chk_model("rst_wv");
    w_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // table-driven fill and drain
    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].fl, tbl[k].wv, tbl[k].wd, tbl[k].rr);
      @(negedge clk);
      cmp("tbl.w_ready", k, int'(wr0), int'(tbl[k].ewr));
      cmp("tbl.r_valid", k, int'(rv0), int'(tbl[k].erv));
      cmp("tbl.level", k, int'(lv0), tbl[k].elv);
      cmp("tbl.almost_full", k, int'(af0), int'(tbl[k].eaf));
      cmp("tbl.almost_empty", k, int'(ae0), int'(tbl[k].eae));
      if (tbl[k].erv) cmp("tbl.r_data", k, int'(rd0), int'(tbl[k].erd));
      post("tbl");
    end

    // wrap-around: write 3, read 3, four times
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 3; j++) begin
        drive(0, 1, 8'(3 * r + j), 0);
        cyc("wrap_w");
      end
      for (int j = 0; j < 3; j++) begin
        drive(0, 0, 8'h00, 1);
        @(negedge clk);
        cmp("wrap.r_data", 0, int'(rd0), 3 * r + j);
        cmp("wrap.level", 0, int'(lv0), 3 - j);
        post("wrap_r");
      end
    end

    // simultaneous read/write at level 2
    drive(0, 1, 8'h20, 0); cyc("sim_w");
    drive(0, 1, 8'h21, 0); cyc("sim_w");
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 8'(8'h22 + k), 1);
      @(negedge clk);
      cmp("sim.level", 0, int'(lv0), 2);
      cmp("sim.r_data", 0, int'(rd0), 8'h20 + k);
      post("sim");
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 8'(8'h28 + k), 0);
      cyc("fill");
    end
    // at full only the read is accepted
    drive(0, 1, 8'h2B, 1);
    @(negedge clk);
    cmp("full_rw.level", 0, int'(lv0), 5);
    cmp("full_rw.w_ready", 0, int'(wr0), 0);
    cmp("full_rw.r_data", 0, int'(rd0), 8'h26);
    post("full_rw");
    drive(0, 0, 8'h00, 0);
    @(negedge clk);
    cmp("after_full.level", 0, int'(lv0), 4);
    cmp("after_full.w_ready", 0, int'(wr0), 1);
    post("after_full");
    drive(0, 0, 8'h00, 1); cyc("to3");

    // flush at level 3
    drive(1, 1, 8'h55, 1);
    @(negedge clk);
    cmp("flush.level", 0, int'(lv0), 3);
    cmp("flush.w_ready", 0, int'(wr0), 0);
    cmp("flush.r_valid", 0, int'(rv0), 0);
    post("flush");
    drive(0, 0, 8'h00, 0);
    @(negedge clk);
    cmp("post_flush.level", 0, int'(lv0), 0);
    cmp("post_flush.almost_empty", 0, int'(ae0), 1);
    cmp("post_flush.r_valid", 0, int'(rv0), 0);
    post("post_flush");

    // fall-through
    drive(0, 1, 8'hAB, 1);
    @(negedge clk);
    cmp("ft.r_valid", 1, int'(rv1), 1);
    cmp("ft.r_data", 1, int'(rd1), 8'hAB);
    post("ft");
    drive(0, 1, 8'hAB, 0);
    @(negedge clk);
    cmp("ft_bypass.level", 1, int'(lv1), 0);
    post("ft_store");
    drive(0, 0, 8'h00, 0);
    @(negedge clk);
    cmp("ft_store.level", 1, int'(lv1), 1);
    cmp("ft_store.r_data", 1, int'(rd1), 8'hAB);
    post("ft_idle");

    // reset mid-operation at level 3
    drive(0, 1, 8'h66, 0); cyc("pre_rst");
    drive(0, 0, 8'h00, 0);
    cmp("pre_rst.level", 0, int'(lv0), 3);
    rstn = 1'b0;
    #1;
    model_clear();
    cmp("mid_rst.level", 0, int'(lv0), 0);
    cmp("mid_rst.w_ready", 0, int'(wr0), 1);
    cmp("mid_rst.r_valid", 0, int'(rv0), 0);
    chk_model("mid_rst");
    #1;
    rstn = 1'b1;
    drive(0, 1, 8'h77, 0);
    cyc("first_w");
    drive(0, 0, 8'h00, 0);
    @(negedge clk);
    cmp("first_w.level", 0, int'(lv0), 1);
    cmp("first_w.r_data", 0, int'(rd0), 8'h77);
    post("first_w_chk");

    // DEPTH=1 alternating write/read
    drive(1, 0, 8'h00, 0); cyc("d1_flush");
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) drive(0, 1, 8'(8'h30 + k), 0);
      else            drive(0, 0, 8'h00, 1);
      @(negedge clk);
      cmp("d1.w_ready", 2, int'(wr2), (k % 2 == 0) ? 1 : 0);
      cmp("d1.complement", 2, int'(wr2 ^ rv2), 1);
      if (k % 2 == 1) cmp("d1.r_data", 2, int'(rd2), 8'h30 + k - 1);
      post("d1");
    end

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1,
            8'($urandom), $urandom_range(0, 2) != 0);
      if (n % 700 == 350) begin
        rstn = 1'b0;
        #1;
        model_clear();
        chk_model("rnd_rst");
        #1;
        rstn = 1'b1;
      end
      cyc("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
